lc3_microsequencer: RTL and testbench

Microsequencer for the LC-3 microcoded controller, directly upstream of the control store. Each cycle it takes the current microinstruction's sequencing fields (IRD, COND, J) plus datapath status and produces the 6-bit next-state address that the control store registers on the next rising edge. It also owns the branch-enable register (BEN), the memory-ready generator (R), and the interrupt-pending latch (INT). It keeps a registered copy of the current state number for debug.

---
 rtl/lc3_microsequencer.sv | 92 +++++++++
 tb/tb_lc3_microsequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: next control-store address, BEN register, memory-ready
// counter and interrupt-pending latch, plus a registered copy of the state number.
module lc3_microsequencer #(
    parameter int MEM_LATENCY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IRD,
    input  logic [2:0] COND,
    input  logic [5:0] J,
    input  logic       LD_BEN,
    input  logic       MIO_EN,
    input  logic       LD_Vector,
    input  logic [6:0] IR,
    input  logic       N,
    input  logic       Z,
    input  logic       P,
    input  logic       PSR15,
    input  logic       INT_req,
    output logic [5:0] Addr_next_state,
    output logic       BEN,
    output logic       R,
    output logic       INT,
    output logic [5:0] state
);

    localparam logic [5:0] FETCH_STATE = 6'd18;
    localparam logic [3:0] CNT_LAST    = 4'(MEM_LATENCY - 1);

    logic [5:0] state_q, state_d;
    logic       ben_q, ben_d;
    logic [3:0] cnt_q, cnt_d;
    logic       int_q, int_d;
    logic       r_rdy;
    logic [5:0] addr_d;

    // Ready fires in the last cycle of the wait and is forced low in reset.
    assign r_rdy = rst_n && MIO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        addr_d = J;
        if (!rst_n) begin
            addr_d = FETCH_STATE;
        end else if (IRD) begin
            addr_d = {2'b00, IR[6:3]};
        end else begin
            unique case (COND)
                3'b001:  addr_d[1] = J[1] | r_rdy;
                3'b010:  addr_d[2] = J[2] | ben_q;
                3'b011:  addr_d[0] = J[0] | IR[2];
                3'b100:  addr_d[3] = J[3] | PSR15;
                3'b101:  addr_d[4] = J[4] | int_q;
                default: addr_d    = J;
            endcase
        end
    end

    always_comb begin
        state_d = addr_d;
        ben_d   = ben_q;
        if (LD_BEN)
            ben_d = (IR[2] & N) | (IR[1] & Z) | (IR[0] & P);
        cnt_d = (!MIO_EN || r_rdy) ? 4'd0 : cnt_q + 4'd1;
        // A simultaneous request and vector load keeps the request pending.
        int_d = int_q;
        if (INT_req)
            int_d = 1'b1;
        else if (LD_Vector)
            int_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_STATE;
            ben_q   <= 1'b0;
            cnt_q   <= 4'd0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ben_q   <= ben_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

    assign Addr_next_state = addr_d;
    assign BEN             = ben_q;
    assign R               = r_rdy;
    assign INT             = int_q;
    assign state           = state_q;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed bench for lc3_microsequencer: expectations are queued as each step is
// driven and popped/checked on the falling edge of that cycle.
module tb_lc3_microsequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IRD;
    logic [2:0] COND;
    logic [5:0] J;
    logic       LD_BEN, MIO_EN, LD_Vector;
    logic [6:0] IR;
    logic       N, Z, P, PSR15, INT_req;
    logic [5:0] Addr_next_state;
    logic       BEN, R, INT;
    logic [5:0] state;

    lc3_microsequencer #(.MEM_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .IRD(IRD), .COND(COND), .J(J),
        .LD_BEN(LD_BEN), .MIO_EN(MIO_EN), .LD_Vector(LD_Vector), .IR(IR),
        .N(N), .Z(Z), .P(P), .PSR15(PSR15), .INT_req(INT_req),
        .Addr_next_state(Addr_next_state), .BEN(BEN), .R(R), .INT(INT),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ADDR, K_R, K_BEN, K_INT, K_STATE} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [5:0]  val;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] next_state_exp;
    bit         next_state_vld = 1'b0;

    task automatic push(input string tag, input kind_t k, input logic [5:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.val = v;
        sb.push_back(e);
        if (k == K_ADDR) begin
            next_state_exp = v;
            next_state_vld = 1'b1;
        end
    endtask

    // Sample at the falling edge, drain the queue, then advance to just after the rising edge.
    task automatic tick();
        exp_t       e;
        logic [5:0] obs;
        bit         have_st;
        logic [5:0] st_exp;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_ADDR:  obs = Addr_next_state;
                K_R:     obs = {5'd0, R};
                K_BEN:   obs = {5'd0, BEN};
                K_INT:   obs = {5'd0, INT};
                default: obs = state;
            endcase
            n_checks++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
        have_st = next_state_vld;
        st_exp  = next_state_exp;
        next_state_vld = 1'b0;
        @(posedge clk);
        #1;
        if (have_st) push("state_follows_addr", K_STATE, st_exp);
    endtask

    task automatic idle();
        IRD = 0; COND = 3'b000; J = 6'd0; LD_BEN = 0; MIO_EN = 0; LD_Vector = 0;
        IR = 7'd0; N = 0; Z = 0; P = 0; PSR15 = 0; INT_req = 0;
    endtask

    initial begin
        // Reset with arbitrary active inputs.
        idle();
        rst_n = 0; IRD = 1; IR = 7'h7F; J = 6'd5; MIO_EN = 1; INT_req = 1;
        LD_BEN = 1; N = 1; Z = 1; P = 1; COND = 3'b101;
        @(posedge clk); #1;
        push("rst_addr0", K_ADDR, 6'd18); push("rst_r0", K_R, 6'd0);
        tick();
        push("rst_addr1", K_ADDR, 6'd18); push("rst_r1", K_R, 6'd0);
        push("rst_ben", K_BEN, 6'd0); push("rst_int", K_INT, 6'd0);
        tick();

        // Release into J=33.
        idle(); rst_n = 1; J = 6'd33;
        push("rel_addr", K_ADDR, 6'd33);
        tick();

        // Branch enable: IR[11:9]=010 with Z.
        idle(); LD_BEN = 1; IR = 7'b0000_010; Z = 1;
        push("ben_before", K_BEN, 6'd0); push("ben_ld_addr", K_ADDR, 6'd0);
        tick();
        idle(); COND = 3'b010; J = 6'd22;
        push("ben_set", K_BEN, 6'd1); push("ben_j22", K_ADDR, 6'd22);
        tick();
        idle(); COND = 3'b010; J = 6'd0;
        push("ben_j0", K_ADDR, 6'd4);
        tick();

        // Decode ignores COND/J, with BEN still 1; second decode also reloads BEN to 0.
        idle(); IRD = 1; IR = 7'b0001_000; J = 6'h3F; COND = 3'b010;
        push("decode_1", K_ADDR, 6'd1);
        tick();
        idle(); IRD = 1; IR = 7'b1111_100; J = 6'h3F; LD_BEN = 1; Z = 1;
        push("decode_15", K_ADDR, 6'd15);
        tick();
        idle(); COND = 3'b010; J = 6'd0;
        push("ben_clr", K_BEN, 6'd0); push("ben_clr_addr", K_ADDR, 6'd0);
        tick();

        // Addressing and privilege.
        idle(); COND = 3'b011; J = 6'd20; IR = 7'b0000_100;
        push("ir11_j20", K_ADDR, 6'd21);
        tick();
        idle(); COND = 3'b100; J = 6'd15; PSR15 = 1;
        push("psr_j15", K_ADDR, 6'd15);
        tick();
        idle(); COND = 3'b100; J = 6'd32; PSR15 = 1;
        push("psr1_j32", K_ADDR, 6'd40);
        tick();
        idle(); COND = 3'b100; J = 6'd32; PSR15 = 0;
        push("psr0_j32", K_ADDR, 6'd32);
        tick();
        idle(); COND = 3'b110; J = 6'd5; PSR15 = 1; IR = 7'h7F;
        push("cond110", K_ADDR, 6'd5);
        tick();
        idle(); COND = 3'b111; J = 6'd8; PSR15 = 1; IR = 7'h7F;
        push("cond111", K_ADDR, 6'd8);
        tick();

        // Memory wait: three cycles, ready only in the third.
        for (int c = 0; c < 3; c++) begin
            idle(); MIO_EN = 1; COND = 3'b001; J = 6'd33;
            push($sformatf("mem_addr_c%0d", c), K_ADDR, (c == 2) ? 6'd35 : 6'd33);
            push($sformatf("mem_r_c%0d", c), K_R, (c == 2) ? 6'd1 : 6'd0);
            tick();
        end
        // Interrupted wait: MIO_EN drops in cycle 2, so the count restarts.
        idle(); MIO_EN = 1; COND = 3'b001; J = 6'd33;
        push("abort_c0", K_R, 6'd0);
        tick();
        idle(); COND = 3'b001; J = 6'd33;
        push("abort_drop", K_R, 6'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); MIO_EN = 1; COND = 3'b001; J = 6'd33;
            push($sformatf("restart_addr_c%0d", c), K_ADDR, (c == 2) ? 6'd35 : 6'd33);
            push($sformatf("restart_r_c%0d", c), K_R, (c == 2) ? 6'd1 : 6'd0);
            tick();
        end

        // Interrupt latch.
        idle(); INT_req = 1;
        push("int_pre", K_INT, 6'd0);
        tick();
        idle(); COND = 3'b101; J = 6'd33;
        push("int_set", K_INT, 6'd1); push("int_j33", K_ADDR, 6'd49);
        tick();
        idle(); LD_Vector = 1;
        push("int_hold", K_INT, 6'd1);
        tick();
        idle(); COND = 3'b101; J = 6'd33;
        push("int_cleared", K_INT, 6'd0); push("int_clr_j33", K_ADDR, 6'd33);
        tick();
        idle(); INT_req = 1; LD_Vector = 1;
        tick();
        idle();
        push("int_set_wins", K_INT, 6'd1);
        tick();

        // Reset mid-wait with an interrupt pending clears both.
        idle(); MIO_EN = 1; COND = 3'b001; J = 6'd33;
        tick();
        idle(); rst_n = 0; MIO_EN = 1; COND = 3'b001; J = 6'd33;
        push("midrst_addr", K_ADDR, 6'd18); push("midrst_r", K_R, 6'd0);
        tick();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            idle(); MIO_EN = 1; COND = 3'b001; J = 6'd33;
            if (c == 0) push("postrst_int", K_INT, 6'd0);
            push($sformatf("postrst_r_c%0d", c), K_R, (c == 2) ? 6'd1 : 6'd0);
            push($sformatf("postrst_addr_c%0d", c), K_ADDR, (c == 2) ? 6'd35 : 6'd33);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
